// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver (8 data bits, even parity, 1 stop); optional rx synchronizer via UART_RX_SYNC_EN
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic       clk_t,
  input  logic       srst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  // Mid-start-bit and full-bit sample points of the sample counter
  localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(OVERSAMPLE - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_bit;
  logic             rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit
  always_ff @(posedge clk_t) begin
    if (srst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];
`else
  assign rx_s = rx;
`endif

  // Receive FSM: start qualification, mid-bit sampling, and registered result/flag outputs
  always_ff @(posedge clk_t) begin
    if (srst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data_out   <= 8'h00;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (rx_s) begin
              // Glitch shorter than half a bit: not a real start bit
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= PARITY;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PARITY: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == FULL) begin
            cnt        <= '0;
            data_out   <= shreg;
            parity_err <= (^shreg) ^ par_bit;
            frame_err  <= ~rx_s;
            valid      <= 1'b1;
            if (rx_s) begin
              // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        BREAK: begin
          // A line held low must return high before another start can be seen
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
module tb_uart_rx;

  localparam int OS = 16;
`ifdef UART_RX_SYNC_EN
  localparam int SO = 2;
`else
  localparam int SO = 0;
`endif
  localparam int LAT = OS / 2 + 10 * OS + SO;

  logic       clk_t = 1'b0;
  logic       srst  = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk_t      (clk_t),
    .srst       (srst),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk_t = ~clk_t;

  int cyc = 0;
  always @(posedge clk_t) cyc++;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bz;
    int         at;
  } exp_t;

  exp_t q[$];
  int   vt[$];
  exp_t e_cur;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid pulse is matched against the oldest expected frame
  always @(negedge clk_t) begin
    if (valid === 1'b1) begin
      vt.push_back(cyc);
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e_cur = q.pop_front();
        chk("data_out", 32'(data_out), 32'(e_cur.d));
        chk("parity_err", 32'(parity_err), 32'(e_cur.pe));
        chk("frame_err", 32'(frame_err), 32'(e_cur.fe));
        chk("busy_at_valid", 32'(busy), 32'(e_cur.bz));
        chk("valid_timing", cyc, e_cur.at);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_t);
      rx = 1'b1;
    end
  endtask

  // Drive the first ncyc cycles of a frame; push an expectation only for complete frames
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic epe, input logic efe, input int ncyc, input bit push);
    logic [10:0] bits;
    exp_t        e;
    bits = {stop, par, d, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_t);
      if (c == 0 && push) begin
        e.d  = d;
        e.pe = epe;
        e.fe = efe;
        e.bz = ~stop;
        e.at = cyc + LAT + 1;
        q.push_back(e);
      end
      rx = bits[c / OS];
    end
  endtask

  int t0;
  int vstart;

  initial begin
    repeat (3) @(negedge clk_t);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_perr", 32'(parity_err), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    srst = 1'b0;
    idle(10);

    // 1: clean 0xA5
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 11 * OS, 1'b1);
    idle(20);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // 2: 0x07 with wrong parity
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 11 * OS, 1'b1);
    idle(20);

    // 3: false start, 4 low cycles
    @(negedge clk_t);
    t0 = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk_t);
    rx = 1'b1;
    while (cyc < t0 + 8 + SO) @(negedge clk_t);
    chk("t3_busy_before", 32'(busy), 32'd1);
    @(negedge clk_t);
    chk("t3_busy_after", 32'(busy), 32'd0);
    chk("t3_data_held", 32'(data_out), 32'h07);
    chk("t3_perr_held", 32'(parity_err), 32'd1);
    idle(20);

    // 4: framing error then break, then recovery with 0x81
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 11 * OS, 1'b1);
    repeat (40) begin
      @(negedge clk_t);
      rx = 1'b0;
    end
    chk("t4_busy_break", 32'(busy), 32'd1);
    idle(4);
    chk("t4_busy_release", 32'(busy), 32'd0);
    idle(10);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 11 * OS, 1'b1);
    idle(20);

    // 5: reset mid-frame at edge 60
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 60, 1'b0);
    @(negedge clk_t);
    srst = 1'b1;
    rx   = 1'b1;
    @(negedge clk_t);
    srst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(valid), 32'd0);
    chk("t5_data", 32'(data_out), 32'h00);
    chk("t5_ferr", 32'(frame_err), 32'd0);
    idle(10);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 11 * OS, 1'b1);
    idle(20);

    // 6: back-to-back 0x00 then 0xFF
    vstart = vt.size();
    send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 11 * OS, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 11 * OS, 1'b1);
    idle(20);
    chk("t6_pulse_count", 32'(vt.size() - vstart), 32'd2);
    if (vt.size() - vstart >= 2) begin
      chk("t6_spacing", 32'(vt[vstart + 1] - vt[vstart]), 32'(11 * OS));
    end

    idle(20);
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
